// File: rtl/bitmap_loader.sv
// bitmap_loader: fetches a 64x24 bitmap as consecutive memory words
// and hands it to the bitmap register with a one-cycle write enable.
module bitmap_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int WORDS  = 96,
    parameter int BMP_W  = 1536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [BMP_W-1:0]  bmr_out,
    output logic              bmr_we
);

    localparam int CNT_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(BMP_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [BMP_W-1:0]  staging;
    logic [BMP_W-1:0]  staging_nxt;
    logic [IDX_W-1:0]  lsb;

    logic load;
    logic capture;
    logic advance;
    logic finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort has priority over grant/rvalid so a cancelled read never lands
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        bmr_we    = 1'b0;
        mem_req   = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (mem_rvalid) begin
                    capture = 1'b1;
                    if (cnt == LAST) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                bmr_we    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign lsb      = IDX_W'(cnt) * IDX_W'(DATA_W);
    assign mem_addr = addr;

    always_comb begin
        staging_nxt = staging;
        staging_nxt[lsb +: DATA_W] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            addr <= '0;
        end else if (load) begin
            cnt  <= '0;
            addr <= base_addr;
        end else if (advance) begin
            cnt  <= cnt + CNT_W'(1);
            addr <= addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
        end else if (capture) begin
            staging <= staging_nxt;
        end
    end

    // the last word is merged in on the way so the bitmap is complete in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmr_out <= '0;
        end else if (finish) begin
            bmr_out <= staging_nxt;
        end
    end

    a_cnt_range: assert property (
        @(posedge clk) disable iff (!rst_n) cnt <= LAST
    );

endmodule

// File: tb/tb_bitmap_loader.sv
// tb_bitmap_loader: directed loads against a simple one-outstanding
// memory model with programmable grant stall and read latency.
module tb_bitmap_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [15:0]   base_addr;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [15:0]   mem_rdata;
    logic [1535:0] bmr_out;
    logic          bmr_we;

    int nchk = 0;
    int nerr = 0;

    bitmap_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .bmr_out   (bmr_out),
        .bmr_we    (bmr_we)
    );

    always #5 clk = ~clk;

    // memory model state
    logic [15:0] exp_addr;
    logic [15:0] dbase;
    logic [15:0] held_addr;
    logic [15:0] pend_data;
    logic        held_valid;
    logic        pend;
    int          pend_wait;
    int          rv_lat;
    int          stall_cfg;
    int          stall_left;
    int          gidx;
    int          addr_err;
    int          stab_err;
    int          we_cnt = 0;
    int          coin_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1535:0] mk(input logic [15:0] db);
        logic [1535:0] r;
        r = '0;
        for (int i = 0; i < 96; i++) r[i*16 +: 16] = db + 16'(i);
        return r;
    endfunction

    task automatic model_init(input logic [15:0] base,
                              input logic [15:0] db, input int stall);
        exp_addr   = base;
        dbase      = db;
        stall_cfg  = stall;
        stall_left = stall;
        rv_lat     = 1;
        pend       = 1'b0;
        held_valid = 1'b0;
        gidx       = 0;
        addr_err   = 0;
        stab_err   = 0;
    endtask

    always @(negedge clk) begin
        if (bmr_we) we_cnt++;
        if (done != bmr_we) coin_err++;
        mem_rvalid = 1'b0;
        if (pend) begin
            if (pend_wait <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        mem_gnt = 1'b0;
        if (mem_req && rst_n) begin
            if (held_valid && mem_addr != held_addr) stab_err++;
            if (stall_left > 0) begin
                stall_left--;
                held_valid = 1'b1;
                held_addr  = mem_addr;
            end else begin
                mem_gnt    = 1'b1;
                held_valid = 1'b0;
                stall_left = stall_cfg;
                if (mem_addr != exp_addr) addr_err++;
                exp_addr   = exp_addr + 16'd1;
                pend       = 1'b1;
                pend_wait  = rv_lat;
                pend_data  = dbase + 16'(gidx);
                gidx++;
            end
        end
    end

    task automatic run_load(input logic [15:0] base, input logic [15:0] db,
                            input int stall, input int extra_at,
                            output int cyc);
        model_init(base, db, stall);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            start     = (extra_at > 0 && cyc == extra_at);
            base_addr = start ? 16'h2000 : base;
            if (done) break;
            if (cyc >= 2000) begin
                check("load_timeout", 32'(cyc), 32'(0));
                break;
            end
        end
        check("we_with_done", 32'(bmr_we), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    int cyc;
    int we0;
    int n;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 16'h0;
        mem_gnt   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0;
        model_init(16'h0, 16'h0, 0);
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(bmr_we), 32'd0);
        check("rst_bmr", 32'(bmr_out == '0), 32'd1);
        #11 rst_n = 1'b1;

        // basic load
        we0 = we_cnt;
        run_load(16'h0100, 16'hA000, 0, 0, cyc);
        check("basic_cycles", 32'(cyc), 32'd193);
        check("basic_addr", 32'(addr_err), 32'd0);
        check("basic_reqs", 32'(gidx), 32'd96);
        check("basic_lo", 32'(bmr_out[15:0]), 32'hA000);
        check("basic_hi", 32'(bmr_out[1535:1520]), 32'hA05F);
        check("basic_all", 32'(bmr_out == mk(16'hA000)), 32'd1);
        check("basic_we", 32'(we_cnt - we0), 32'd1);
        check("basic_idle", 32'(busy), 32'd0);

        // wrap-around
        run_load(16'hFFF0, 16'hB000, 0, 0, cyc);
        check("wrap_addr", 32'(addr_err), 32'd0);
        check("wrap_reqs", 32'(gidx), 32'd96);
        check("wrap_lo", 32'(bmr_out[15:0]), 32'hB000);
        check("wrap_all", 32'(bmr_out == mk(16'hB000)), 32'd1);

        // grant stalls
        run_load(16'h0100, 16'hA000, 5, 0, cyc);
        check("stall_cycles", 32'(cyc), 32'd673);
        check("stall_stable", 32'(stab_err), 32'd0);
        check("stall_addr", 32'(addr_err), 32'd0);
        check("stall_all", 32'(bmr_out == mk(16'hA000)), 32'd1);

        // abort with a read still outstanding
        we0 = we_cnt;
        model_init(16'h0400, 16'hD000, 0);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 16'h0400;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (gidx < 40 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        rv_lat = 3;
        while (gidx < 41 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("abort_reach", 32'(n < 1000), 32'd1);
        check("abort_in_wait", 32'(busy && !mem_req), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_stray", 32'(pend), 32'd0);
        check("abort_idle", 32'(busy | mem_req), 32'd0);
        check("abort_no_we", 32'(we_cnt - we0), 32'd0);
        check("abort_keep", 32'(bmr_out == mk(16'hA000)), 32'd1);

        run_load(16'h0300, 16'hC000, 0, 0, cyc);
        check("reload_addr", 32'(addr_err), 32'd0);
        check("reload_lo", 32'(bmr_out[15:0]), 32'hC000);
        check("reload_all", 32'(bmr_out == mk(16'hC000)), 32'd1);

        // start while busy
        run_load(16'h0500, 16'hE000, 0, 20, cyc);
        check("busy_start_cyc", 32'(cyc), 32'd193);
        check("busy_start_addr", 32'(addr_err), 32'd0);
        check("busy_start_reqs", 32'(gidx), 32'd96);
        check("busy_start_all", 32'(bmr_out == mk(16'hE000)), 32'd1);

        // async reset mid-WAIT
        model_init(16'h0600, 16'h1000, 0);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 16'h0600;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (gidx < 50 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("rst_in_wait", 32'(busy && !mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_bmr", 32'(bmr_out == '0), 32'd1);
        @(negedge clk);
        model_init(16'h0, 16'h0, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_idle", 32'(busy), 32'd0);
        check("arst_bmr_after", 32'(bmr_out == '0), 32'd1);

        run_load(16'h0700, 16'h7000, 0, 0, cyc);
        check("post_rst_all", 32'(bmr_out == mk(16'h7000)), 32'd1);
        check("done_eq_we", 32'(coin_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/bitmap_loader.md
Name: bitmap_loader

Overview:
- Reads one 1536-bit bitmap (64 rows x 24 bits) from word-addressed data memory and assembles it for the bitmap register file. This is the load path that complements the ALU's bitmap output path (alu_bmo).
- A single start pulse triggers a fetch of 96 consecutive 16-bit words over a request/grant/rvalid memory port.
- When the fetch completes, the assembled bitmap is presented together with a one-cycle write-enable to the bitmap register.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 16, memory address width.
- WORDS, 96, words per bitmap; WORDS*DATA_W must equal BMP_W.
- BMP_W, 1536, bitmap width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- abort  input  1  cancels a load in progress.
- base_addr  input  ADDR_W  first word address; sampled together with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  read address; held stable while mem_req is high.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  mem_rdata is valid this cycle.
- mem_rdata  input  DATA_W  read data.
- bmr_out  output  BMP_W  assembled bitmap.
- bmr_we  output  1  bitmap register write enable; one-cycle pulse, coincident with done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, word counter=0, address register=0, staging register=0, bmr_out=0. All outputs are 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start=1, latch base_addr into the address register, clear the counter, go to REQ.
  - start is ignored in every other state; no queuing.
- REQ:
  - mem_req=1 and mem_addr=address register.
  - When mem_gnt=1, go to WAIT.
  - mem_req and mem_addr must not change until grant.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1, write mem_rdata into staging[DATA_W*cnt +: DATA_W]; word 0 lands in bits [15:0], word 95 in bits [1535:1520].
  - If cnt==WORDS-1, go to DONE. Otherwise increment cnt and the address register, and go to REQ.
  - mem_rvalid is never asserted in the same cycle as its grant; a bench must not drive it that way.
- Outstanding reads: only one at a time. The minimum load time is 2*WORDS+1 cycles from start to done (193 for the defaults).
- DONE:
  - For exactly one cycle: done=1, bmr_we=1, bmr_out<=staging (visible from this cycle on).
  - Next state is IDLE.
- bmr_out changes only on DONE entry. It holds its previous bitmap throughout a load and after an abort.
- Address arithmetic: base_addr + cnt modulo 2^ADDR_W. Wraps past 0xFFFF to 0x0000 with no error.
- Counter: 7 bits. Never exceeds WORDS-1.
- abort:
  - In REQ or WAIT: go to IDLE next cycle, with no done and no bmr_we.
  - Aborting while a request is granted but its data is still pending: the late mem_rvalid arriving in IDLE is ignored.
  - In IDLE or DONE: abort has no effect; DONE still completes.
  - abort and start together in IDLE: start wins.
- A reset mid-load discards the staging register and clears bmr_out to 0.

Test Plan:
- Basic load: base_addr=0x0100; memory returns word i = 0xA000+i with one cycle of gnt and rvalid latency -> addresses 0x0100..0x015F are issued in order; done/bmr_we pulse once; bmr_out[15:0]=0xA000 and bmr_out[1535:1520]=0xA05F; done arrives exactly 193 cycles after start.
- Wrap-around: base_addr=0xFFF0 -> addresses run 0xFFF0..0xFFFF then 0x0000..0x004F; data lands correctly.
- Grant stalls: mem_gnt held low 5 cycles on every request -> mem_req and mem_addr stay stable during each stall; the final bitmap matches the basic-load result.
- Abort: abort asserted in WAIT after word 40 -> busy falls next cycle; no bmr_we; bmr_out keeps the prior bitmap. A stray rvalid in IDLE is ignored, and a following start loads correctly.
- Start while busy: a second start with base_addr=0x2000 during a load -> ignored; all addresses continue from the original base.
- Async reset: rst_n pulsed low mid-WAIT, between clock edges -> all outputs 0 immediately; state is IDLE after release; bmr_out=0.
